// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the program counter, drives the instruction
// memory address and tracks the PC of the word the memory returns one edge
// later. Handles stall, branch/jump redirect and out-of-range or misaligned
// fetch faults, which halt the unit until reset.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_BYTES = 512
) (
    input  logic        clock,
    input  logic        resetN,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirectTarget,
    output logic [31:0] instructionAdress,
    output logic [31:0] fetchPc,
    output logic [31:0] fetchPcPlus4,
    output logic        fetchValid,
    output logic        fetchFault,
    output logic [31:0] faultAddr
);

    // Highest byte address at which a whole word can still be fetched.
    localparam logic [31:0] LAST_ADDR = 32'(MEM_BYTES - 4);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  fetch_pc;
    logic         fetch_valid;
    logic [31:0]  fault_addr;
    logic         pc_bad;

    // The address about to be fetched is illegal if it runs off the end of
    // memory or is not word aligned.
    always_comb begin
        pc_bad = (pc > LAST_ADDR) || (pc[1:0] != 2'b00);
    end

    // Fetch state machine: reset > redirect > stall > sequential while running;
    // only reset leaves HALT.
    always_ff @(posedge clock) begin
        if (!resetN) begin
            state       <= RUN;
            pc          <= RESET_PC;
            fetch_pc    <= RESET_PC;
            fetch_valid <= 1'b0;
            fault_addr  <= 32'h0000_0000;
        end else begin
            case (state)
                RUN: begin
                    if (redirect) begin
                        fetch_valid <= 1'b0;
                        fetch_pc    <= pc;
                        pc          <= redirectTarget;
                    end else if (stall) begin
                        fetch_valid <= fetch_valid;
                    end else if (pc_bad) begin
                        state       <= HALT;
                        fetch_valid <= 1'b0;
                        fault_addr  <= pc;
                    end else begin
                        fetch_pc    <= pc;
                        fetch_valid <= 1'b1;
                        pc          <= pc + 32'd4;
                    end
                end
                HALT: begin
                    fetch_valid <= 1'b0;
                end
                default: begin
                    state       <= HALT;
                    fetch_valid <= 1'b0;
                end
            endcase
        end
    end

    // During a stall the memory re-reads the held word so instructionOut stays
    // aligned with fetchPc; a redirect always overrides the stall.
    always_comb begin
        instructionAdress = (stall && !redirect) ? fetch_pc : pc;
    end

    // Decode-facing outputs.
    always_comb begin
        fetchPc      = fetch_pc;
        fetchPcPlus4 = fetch_pc + 32'd4;
        fetchValid   = fetch_valid;
        fetchFault   = (state == HALT);
        faultAddr    = fault_addr;
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit. Each scenario task builds a
// list of stimulus rows with the expected post-edge outputs, pushes the
// expectation to a scoreboard queue as it drives the row, and pops/compares
// once the DUT has updated after the edge.
module tb_instruction_fetch_unit;

    logic        clock;
    logic        resetN;
    logic        stall;
    logic        redirect;
    logic [31:0] redirectTarget;
    logic [31:0] instructionAdress;
    logic [31:0] fetchPc;
    logic [31:0] fetchPcPlus4;
    logic        fetchValid;
    logic        fetchFault;
    logic [31:0] faultAddr;

    int vectors;
    int miscompares;

    typedef struct packed {
        logic [31:0] fpc;
        logic [31:0] fpc4;
        logic        valid;
        logic        fault;
        logic [31:0] faddr;
        logic [31:0] addr;
    } obs_t;

    typedef struct packed {
        logic        rst_n;
        logic        stl;
        logic        rdr;
        logic [31:0] tgt;
        obs_t        exp;
    } row_t;

    obs_t scoreboard[$];

    instruction_fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .MEM_BYTES (512)
    ) dut (
        .clock             (clock),
        .resetN            (resetN),
        .stall             (stall),
        .redirect          (redirect),
        .redirectTarget    (redirectTarget),
        .instructionAdress (instructionAdress),
        .fetchPc           (fetchPc),
        .fetchPcPlus4      (fetchPcPlus4),
        .fetchValid        (fetchValid),
        .fetchFault        (fetchFault),
        .faultAddr         (faultAddr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Build one stimulus row; fetchPcPlus4 expectation is fpc + 4.
    function automatic row_t mk(input logic rst_n, input logic stl, input logic rdr,
                                input logic [31:0] tgt, input logic [31:0] fpc,
                                input logic valid, input logic fault,
                                input logic [31:0] faddr, input logic [31:0] addr);
        row_t r;
        r.rst_n     = rst_n;
        r.stl       = stl;
        r.rdr       = rdr;
        r.tgt       = tgt;
        r.exp.fpc   = fpc;
        r.exp.fpc4  = fpc + 32'd4;
        r.exp.valid = valid;
        r.exp.fault = fault;
        r.exp.faddr = faddr;
        r.exp.addr  = addr;
        return r;
    endfunction

    // Drive one row and wait until just after the edge it applies to.
    task automatic apply_row(input row_t r);
        resetN         = r.rst_n;
        stall          = r.stl;
        redirect       = r.rdr;
        redirectTarget = r.tgt;
        scoreboard.push_back(r.exp);
        @(posedge clock);
        #1;
    endtask

    function automatic obs_t observe();
        obs_t o;
        o.fpc   = fetchPc;
        o.fpc4  = fetchPcPlus4;
        o.valid = fetchValid;
        o.fault = fetchFault;
        o.faddr = faultAddr;
        o.addr  = instructionAdress;
        return o;
    endfunction

    task automatic test_reset();
        row_t rows[$];
        obs_t got, exp;
        rows.push_back(mk(0, 0, 0, 0, 32'h0,  0, 0, 0, 32'h0));
        rows.push_back(mk(0, 0, 0, 0, 32'h0,  0, 0, 0, 32'h0));
        rows.push_back(mk(1, 0, 0, 0, 32'h0,  1, 0, 0, 32'h4));
        rows.push_back(mk(1, 0, 0, 0, 32'h4,  1, 0, 0, 32'h8));
        rows.push_back(mk(1, 0, 0, 0, 32'h8,  1, 0, 0, 32'hC));
        rows.push_back(mk(1, 0, 0, 0, 32'hC,  1, 0, 0, 32'h10));
        foreach (rows[i]) begin
            apply_row(rows[i]);
            got = observe();
            exp = scoreboard.pop_front();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("[TB] FAIL test_reset[%0d] got fpc=%h+4=%h v=%b f=%b fa=%h ia=%h want fpc=%h+4=%h v=%b f=%b fa=%h ia=%h",
                         i, got.fpc, got.fpc4, got.valid, got.fault, got.faddr, got.addr,
                         exp.fpc, exp.fpc4, exp.valid, exp.fault, exp.faddr, exp.addr);
            end
        end
    endtask

    task automatic test_stall();
        row_t rows[$];
        obs_t got, exp;
        rows.push_back(mk(1, 1, 0, 0, 32'hC,  1, 0, 0, 32'hC));
        rows.push_back(mk(1, 1, 0, 0, 32'hC,  1, 0, 0, 32'hC));
        rows.push_back(mk(1, 0, 0, 0, 32'h10, 1, 0, 0, 32'h14));
        foreach (rows[i]) begin
            apply_row(rows[i]);
            got = observe();
            exp = scoreboard.pop_front();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("[TB] FAIL test_stall[%0d] got fpc=%h+4=%h v=%b f=%b fa=%h ia=%h want fpc=%h+4=%h v=%b f=%b fa=%h ia=%h",
                         i, got.fpc, got.fpc4, got.valid, got.fault, got.faddr, got.addr,
                         exp.fpc, exp.fpc4, exp.valid, exp.fault, exp.faddr, exp.addr);
            end
        end
    endtask

    task automatic test_redirect();
        row_t rows[$];
        obs_t got, exp;
        rows.push_back(mk(1, 0, 1, 32'h28, 32'h14, 0, 0, 0, 32'h28));
        rows.push_back(mk(1, 0, 0, 0,      32'h28, 1, 0, 0, 32'h2C));
        foreach (rows[i]) begin
            apply_row(rows[i]);
            got = observe();
            exp = scoreboard.pop_front();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("[TB] FAIL test_redirect[%0d] got fpc=%h+4=%h v=%b f=%b fa=%h ia=%h want fpc=%h+4=%h v=%b f=%b fa=%h ia=%h",
                         i, got.fpc, got.fpc4, got.valid, got.fault, got.faddr, got.addr,
                         exp.fpc, exp.fpc4, exp.valid, exp.fault, exp.faddr, exp.addr);
            end
        end
    endtask

    task automatic test_redirect_with_stall();
        row_t rows[$];
        obs_t got, exp;
        rows.push_back(mk(1, 1, 1, 32'h28, 32'h2C, 0, 0, 0, 32'h28));
        rows.push_back(mk(1, 0, 0, 0,      32'h28, 1, 0, 0, 32'h2C));
        foreach (rows[i]) begin
            apply_row(rows[i]);
            got = observe();
            exp = scoreboard.pop_front();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("[TB] FAIL test_redirect_with_stall[%0d] got fpc=%h+4=%h v=%b f=%b fa=%h ia=%h want fpc=%h+4=%h v=%b f=%b fa=%h ia=%h",
                         i, got.fpc, got.fpc4, got.valid, got.fault, got.faddr, got.addr,
                         exp.fpc, exp.fpc4, exp.valid, exp.fault, exp.faddr, exp.addr);
            end
        end
    endtask

    task automatic test_faults();
        row_t rows[$];
        obs_t got, exp;
        // Misaligned redirect target: bubble, then halt; redirect ignored.
        rows.push_back(mk(1, 0, 1, 32'h2A,  32'h2C,  0, 0, 0,       32'h2A));
        rows.push_back(mk(1, 0, 0, 0,       32'h2C,  0, 1, 32'h2A,  32'h2A));
        rows.push_back(mk(1, 0, 1, 32'h40,  32'h2C,  0, 1, 32'h2A,  32'h2A));
        rows.push_back(mk(1, 0, 0, 0,       32'h2C,  0, 1, 32'h2A,  32'h2A));
        rows.push_back(mk(0, 0, 0, 0,       32'h0,   0, 0, 0,       32'h0));
        rows.push_back(mk(1, 0, 0, 0,       32'h0,   1, 0, 0,       32'h4));
        // Out-of-range redirect target.
        rows.push_back(mk(1, 0, 1, 32'h200, 32'h4,   0, 0, 0,       32'h200));
        rows.push_back(mk(1, 0, 0, 0,       32'h4,   0, 1, 32'h200, 32'h200));
        rows.push_back(mk(0, 0, 0, 0,       32'h0,   0, 0, 0,       32'h0));
        // Sequential run off the end of memory.
        rows.push_back(mk(1, 0, 1, 32'h1F8, 32'h0,   0, 0, 0,       32'h1F8));
        rows.push_back(mk(1, 0, 0, 0,       32'h1F8, 1, 0, 0,       32'h1FC));
        rows.push_back(mk(1, 0, 0, 0,       32'h1FC, 1, 0, 0,       32'h200));
        rows.push_back(mk(1, 0, 0, 0,       32'h1FC, 0, 1, 32'h200, 32'h200));
        rows.push_back(mk(1, 0, 1, 32'h0,   32'h1FC, 0, 1, 32'h200, 32'h200));
        foreach (rows[i]) begin
            apply_row(rows[i]);
            got = observe();
            exp = scoreboard.pop_front();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("[TB] FAIL test_faults[%0d] got fpc=%h+4=%h v=%b f=%b fa=%h ia=%h want fpc=%h+4=%h v=%b f=%b fa=%h ia=%h",
                         i, got.fpc, got.fpc4, got.valid, got.fault, got.faddr, got.addr,
                         exp.fpc, exp.fpc4, exp.valid, exp.fault, exp.faddr, exp.addr);
            end
        end
    endtask

    task automatic test_reset_override();
        row_t rows[$];
        obs_t got, exp;
        // Reset while halted.
        rows.push_back(mk(0, 0, 0, 0, 32'h0, 0, 0, 0, 32'h0));
        rows.push_back(mk(1, 0, 0, 0, 32'h0, 1, 0, 0, 32'h4));
        rows.push_back(mk(1, 0, 0, 0, 32'h4, 1, 0, 0, 32'h8));
        // Reset while stalled.
        rows.push_back(mk(1, 1, 0, 0, 32'h4, 1, 0, 0, 32'h4));
        rows.push_back(mk(0, 1, 0, 0, 32'h0, 0, 0, 0, 32'h0));
        rows.push_back(mk(1, 0, 0, 0, 32'h0, 1, 0, 0, 32'h4));
        foreach (rows[i]) begin
            apply_row(rows[i]);
            got = observe();
            exp = scoreboard.pop_front();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("[TB] FAIL test_reset_override[%0d] got fpc=%h+4=%h v=%b f=%b fa=%h ia=%h want fpc=%h+4=%h v=%b f=%b fa=%h ia=%h",
                         i, got.fpc, got.fpc4, got.valid, got.fault, got.faddr, got.addr,
                         exp.fpc, exp.fpc4, exp.valid, exp.fault, exp.faddr, exp.addr);
            end
        end
    endtask

    initial begin
        vectors        = 0;
        miscompares    = 0;
        resetN         = 1'b0;
        stall          = 1'b0;
        redirect       = 1'b0;
        redirectTarget = 32'h0;
        #1;
        test_reset();
        test_stall();
        test_redirect();
        test_redirect_with_stall();
        test_faults();
        test_reset_override();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
